// File: rtl/fp_addsub_prealign_stage.sv
// First FP add/sub pipeline stage: unpack, classify, order by magnitude and
// apply the 16-bit and 0..3-bit parts of the alignment shift to the smaller mantissa.
module fp_addsub_prealign_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] MminP,
  output logic [31:0] Mmax,
  output logic [4:0]  Shift,
  output logic [7:0]  Emax,
  output logic        Smax,
  output logic        EffSub,
  output logic        Swapped,
  output logic [4:0]  InputExc
);

  // Hidden bit is implied by a non-zero exponent; exp == 0 flushes to zero.
  function automatic logic [31:0] unpack_mant(input logic [31:0] x);
    logic [31:0] m;
    if (x[30:23] != 8'd0) begin
      m = {1'b1, x[22:0], 8'd0};
    end else begin
      m = 32'd0;
    end
    return m;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  logic        load_s;
  logic [31:0] ma_s, mb_s, mmax_s, mmin_s, stage16_s, mminp_s;
  logic [7:0]  emax_s, emin_s, diff_s;
  logic [4:0]  shift_s, exc_s;
  logic        smax_s, effsub_s, swapped_s;

  logic        out_valid_r;
  logic [31:0] mminp_r, mmax_r;
  logic [4:0]  shift_r, exc_r;
  logic [7:0]  emax_r;
  logic        smax_r, effsub_r, swapped_r;

  assign in_ready = !out_valid_r || out_ready;
  assign load_s   = in_valid && in_ready;

  // Next-result datapath: ordering, exponent difference and partial alignment.
  always_comb begin
    ma_s      = unpack_mant(A);
    mb_s      = unpack_mant(B);
    mmax_s    = 32'd0;
    mmin_s    = 32'd0;
    emax_s    = 8'd0;
    emin_s    = 8'd0;
    smax_s    = 1'b0;
    swapped_s = 1'b0;
    stage16_s = 32'd0;
    mminp_s   = 32'd0;
    shift_s   = 5'd0;
    if (A[30:0] >= B[30:0]) begin
      mmax_s    = ma_s;
      mmin_s    = mb_s;
      emax_s    = A[30:23];
      emin_s    = B[30:23];
      smax_s    = A[31];
      swapped_s = 1'b0;
    end else begin
      mmax_s    = mb_s;
      mmin_s    = ma_s;
      emax_s    = B[30:23];
      emin_s    = A[30:23];
      smax_s    = B[31] ^ Op;
      swapped_s = 1'b1;
    end
    diff_s   = emax_s - emin_s;
    effsub_s = A[31] ^ B[31] ^ Op;
    if (diff_s >= 8'd32) begin
      shift_s = 5'd0;
      mminp_s = 32'd0;
    end else begin
      shift_s = diff_s[4:0];
      if (shift_s[4]) begin
        stage16_s = mmin_s >> 5'd16;
      end else begin
        stage16_s = mmin_s;
      end
      // Shift[3:2] is deliberately left for the next stage.
      mminp_s = stage16_s >> shift_s[1:0];
    end
    exc_s = {is_nan(A) || is_nan(B) || is_inf(A) || is_inf(B),
             is_nan(A), is_nan(B), is_inf(A), is_inf(B)};
  end

  // Output register with valid/ready handshake; holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      mminp_r     <= 32'd0;
      mmax_r      <= 32'd0;
      shift_r     <= 5'd0;
      emax_r      <= 8'd0;
      smax_r      <= 1'b0;
      effsub_r    <= 1'b0;
      swapped_r   <= 1'b0;
      exc_r       <= 5'd0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      mminp_r     <= mminp_s;
      mmax_r      <= mmax_s;
      shift_r     <= shift_s;
      emax_r      <= emax_s;
      smax_r      <= smax_s;
      effsub_r    <= effsub_s;
      swapped_r   <= swapped_s;
      exc_r       <= exc_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign MminP     = mminp_r;
  assign Mmax      = mmax_r;
  assign Shift     = shift_r;
  assign Emax      = emax_r;
  assign Smax      = smax_r;
  assign EffSub    = effsub_r;
  assign Swapped   = swapped_r;
  assign InputExc  = exc_r;

endmodule

// File: tb/tb_fp_addsub_prealign_stage.sv
// Directed bench for fp_addsub_prealign_stage: hand-derived expected results
// are queued on accept and compared when the stage hands a result downstream.
module tb_fp_addsub_prealign_stage;

  typedef struct packed {
    logic [31:0] mminp;
    logic [31:0] mmax;
    logic [4:0]  shift;
    logic [7:0]  emax;
    logic        smax;
    logic        effsub;
    logic        swapped;
    logic [4:0]  exc;
  } exp_t;

  logic        clk, rst, in_valid, in_ready, Op, out_valid, out_ready;
  logic [31:0] A, B, MminP, Mmax;
  logic [4:0]  Shift, InputExc;
  logic [7:0]  Emax;
  logic        Smax, EffSub, Swapped;

  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];
  exp_t pend;
  logic accepted;

  logic [31:0] va [12];
  logic [31:0] vb [12];
  logic        vop[12];
  exp_t        ve [12];

  fp_addsub_prealign_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op), .out_valid(out_valid), .out_ready(out_ready),
    .MminP(MminP), .Mmax(Mmax), .Shift(Shift), .Emax(Emax), .Smax(Smax),
    .EffSub(EffSub), .Swapped(Swapped), .InputExc(InputExc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] mminp, input logic [31:0] mmax,
                              input logic [4:0] sh, input logic [7:0] em,
                              input logic sm, input logic es, input logic sw,
                              input logic [4:0] ex);
    exp_t e;
    e.mminp = mminp; e.mmax = mmax; e.shift = sh; e.emax = em;
    e.smax = sm; e.effsub = es; e.swapped = sw; e.exc = ex;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".MminP"},    MminP,            e.mminp);
    chk({tag, ".Mmax"},     Mmax,             e.mmax);
    chk({tag, ".Shift"},    {27'd0, Shift},   {27'd0, e.shift});
    chk({tag, ".Emax"},     {24'd0, Emax},    {24'd0, e.emax});
    chk({tag, ".Smax"},     {31'd0, Smax},    {31'd0, e.smax});
    chk({tag, ".EffSub"},   {31'd0, EffSub},  {31'd0, e.effsub});
    chk({tag, ".Swapped"},  {31'd0, Swapped}, {31'd0, e.swapped});
    chk({tag, ".InputExc"}, {27'd0, InputExc},{27'd0, e.exc});
  endtask

  // One clock: pop/compare a handed-off result, queue an accepted input.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      tests++;
      assert (sb.size() > 0) else begin
        failed++;
        $error("FAIL unexpected_output observed=1 expected=0");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("result", e);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1; A = a; B = b; Op = op; pend = e; accepted = 1'b0;
    while (!accepted && n < 20) begin
      cycle();
      n++;
    end
    tests++;
    assert (accepted) else begin
      failed++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    tests++;
    assert (sb.size() == 0) else begin
      failed++;
      $error("FAIL drain observed=%0d expected=0", sb.size());
    end
    chk("idle_after_drain", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    va[0]  = 32'h3F800000; vb[0]  = 32'h3F000000; vop[0]  = 1'b0;
    ve[0]  = mk(32'h40000000, 32'h80000000, 5'd1,  8'h7F, 1'b0, 1'b0, 1'b0, 5'b00000);
    va[1]  = 32'h3F800000; vb[1]  = 32'h36800000; vop[1]  = 1'b0;
    ve[1]  = mk(32'h00002000, 32'h80000000, 5'd18, 8'h7F, 1'b0, 1'b0, 1'b0, 5'b00000);
    va[2]  = 32'h3F800000; vb[2]  = 32'h3D800000; vop[2]  = 1'b0;
    ve[2]  = mk(32'h80000000, 32'h80000000, 5'd4,  8'h7F, 1'b0, 1'b0, 1'b0, 5'b00000);
    va[3]  = 32'h3F000000; vb[3]  = 32'hBF800000; vop[3]  = 1'b0;
    ve[3]  = mk(32'h40000000, 32'h80000000, 5'd1,  8'h7F, 1'b1, 1'b1, 1'b1, 5'b00000);
    va[4]  = 32'h3F800000; vb[4]  = 32'h2B800000; vop[4]  = 1'b0;
    ve[4]  = mk(32'h00000000, 32'h80000000, 5'd0,  8'h7F, 1'b0, 1'b0, 1'b0, 5'b00000);
    va[5]  = 32'h7FC00000; vb[5]  = 32'hFF800000; vop[5]  = 1'b0;
    ve[5]  = mk(32'h80000000, 32'hC0000000, 5'd0,  8'hFF, 1'b0, 1'b1, 1'b0, 5'b11001);
    va[6]  = 32'h00400000; vb[6]  = 32'h3F800000; vop[6]  = 1'b0;
    ve[6]  = mk(32'h00000000, 32'h80000000, 5'd0,  8'h7F, 1'b0, 1'b0, 1'b1, 5'b00000);
    va[7]  = 32'h3F800000; vb[7]  = 32'h3F800000; vop[7]  = 1'b1;
    ve[7]  = mk(32'h80000000, 32'h80000000, 5'd0,  8'h7F, 1'b0, 1'b1, 1'b0, 5'b00000);
    va[8]  = 32'h3F800000; vb[8]  = 32'h40000000; vop[8]  = 1'b1;
    ve[8]  = mk(32'h40000000, 32'h80000000, 5'd1,  8'h80, 1'b1, 1'b1, 1'b1, 5'b00000);
    va[9]  = 32'h3F800000; vb[9]  = 32'h30000000; vop[9]  = 1'b0;
    ve[9]  = mk(32'h00001000, 32'h80000000, 5'd31, 8'h7F, 1'b0, 1'b0, 1'b0, 5'b00000);
    va[10] = 32'h3F800000; vb[10] = 32'h2F800000; vop[10] = 1'b0;
    ve[10] = mk(32'h00000000, 32'h80000000, 5'd0,  8'h7F, 1'b0, 1'b0, 1'b0, 5'b00000);
    va[11] = 32'h3FC00000; vb[11] = 32'h3FA00000; vop[11] = 1'b0;
    ve[11] = mk(32'hA0000000, 32'hC0000000, 5'd0,  8'h7F, 1'b0, 1'b0, 1'b0, 5'b00000);

    rst = 1'b0; in_valid = 1'b0; A = 32'd0; B = 32'd0; Op = 1'b0; out_ready = 1'b1;
    pend = '0; accepted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    cmp("reset", '0);
    rst = 1'b1;
    #1;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back directed vectors at full throughput.
    for (int i = 0; i < 12; i++) begin
      send(va[i], vb[i], vop[i], ve[i]);
    end
    drain();

    // Backpressure: hold the first result, the rest must wait.
    out_ready = 1'b0;
    send(va[0], vb[0], vop[0], ve[0]);
    in_valid = 1'b1; A = va[3]; B = vb[3]; Op = vop[3];
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
      cmp("stall", ve[0]);
    end
    out_ready = 1'b1;
    send(va[3], vb[3], vop[3], ve[3]);
    chk("stream.no_bubble1", {31'd0, out_valid}, 32'd1);
    send(va[5], vb[5], vop[5], ve[5]);
    chk("stream.no_bubble2", {31'd0, out_valid}, 32'd1);
    drain();

    // Asynchronous reset while a stalled result is held.
    out_ready = 1'b0;
    send(va[1], vb[1], vop[1], ve[1]);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
    cmp("async_rst", '0);
    sb.delete();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
    send(va[8], vb[8], vop[8], ve[8]);
    chk("post_rst.latency", {31'd0, out_valid}, 32'd1);
    cmp("post_rst", ve[8]);
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
